// File: rtl/rename_pkg.sv
// Shared types for the register-rename slice.
//   a_reg_t     : architectural register reference {valid, 5-bit idx}
//   p_reg_t     : physical register reference {valid, idx}
//   p_src_t     : renamed source operand {valid, idx, ready}
//   dinstr_t    : decoded instruction entering rename
//   rinstr_t    : renamed instruction leaving rename
//   br_result_t : branch resolution {valid, hit}
//   map_t       : full architectural -> physical map table
// PREG_W is fixed here from NUM_PREGS_DEF; rename_ckpt's NUM_PREGS must agree.
package rename_pkg;

  localparam int NUM_AREGS     = 32;
  localparam int AREG_W        = 5;
  localparam int NUM_PREGS_DEF = 64;
  localparam int PREG_W        = $clog2(NUM_PREGS_DEF);

  typedef struct packed {
    logic              valid;
    logic [AREG_W-1:0] idx;
  } a_reg_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] idx;
    logic              ready;
  } p_src_t;

  typedef struct packed {
    logic   valid;
    a_reg_t rd;
    a_reg_t rs1;
    a_reg_t rs2;
    logic   is_branch;
  } dinstr_t;

  typedef struct packed {
    logic   valid;
    p_reg_t rd;
    p_reg_t old_rd;
    p_src_t rs1;
    p_src_t rs2;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  typedef logic [NUM_AREGS-1:0][PREG_W-1:0] map_t;

endpackage

// File: rtl/rename_ckpt_if.sv
// Bundle of the rename stage's data-path signals, for connecting a producer
// (decode side, master) to the rename stage (slave).
//   dinstr / p_commit / retire / br_result : into rename
//   rinstr / rn_full                        : out of rename
interface rename_ckpt_if;

  rename_pkg::dinstr_t    dinstr;
  rename_pkg::p_reg_t     p_commit;
  rename_pkg::p_reg_t     retire;
  rename_pkg::br_result_t br_result;
  rename_pkg::rinstr_t    rinstr;
  logic                   rn_full;

  modport master (
    output dinstr, p_commit, retire, br_result,
    input  rinstr, rn_full
  );

  modport slave (
    input  dinstr, p_commit, retire, br_result,
    output rinstr, rn_full
  );

endinterface

// File: rtl/rename_free_list.sv
// Free physical register FIFO.
//   alloc_i        : pop the head entry this cycle
//   retire_i       : push retire_i.idx at the tail (may coincide with alloc)
//   restore_i      : load head from restore_head_i (wins over alloc)
//   head_idx_o     : physical register at the head
//   empty_o        : no free register (registered pointers only)
//   head_snap_o    : head pointer after this cycle's alloc, for checkpoints
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// Restoring the head works because entries between an old head and the
// current head are never overwritten while checkpoints could reach them.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  localparam int DEPTH    = NUM_PREGS - NUM_AREGS,
  localparam int AW       = $clog2(DEPTH),
  localparam int PTR_W    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  p_reg_t           retire_i,
  input  logic             restore_i,
  input  logic [PTR_W-1:0] restore_head_i,
  output logic [PREG_W-1:0] head_idx_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] head_snap_o
);

  logic [PREG_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  head_d;

  assign head_idx_o  = fifo_q[head_q[AW-1:0]];
  assign empty_o     = (head_q == tail_q);
  assign head_snap_o = head_q + {{AW{1'b0}}, alloc_i};
  assign head_d      = restore_i ? restore_head_i : head_snap_o;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      // Full at reset: tail is one lap ahead of head.
      tail_q <= PTR_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= PREG_W'(NUM_AREGS + i);
      end
    end else begin
      head_q <= head_d;
      if (retire_i.valid) begin
        fifo_q[tail_q[AW-1:0]] <= retire_i.idx;
        tail_q                 <= tail_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/rename_ckpt.sv
// Register rename stage with branch checkpoints.
//   clk, rst_ni   : clock, asynchronous active-low reset
//   dinstr_i      : decoded instruction
//   p_commit_i    : writeback notice, marks a physical register ready
//   retire_i      : returns a physical register to the free list
//   br_result_i   : resolves the oldest outstanding branch
//   rinstr_o      : renamed instruction (combinational from dinstr_i)
//   rn_full_o     : stage cannot accept an instruction this cycle
// Handshake: an instruction is consumed in a cycle exactly when
// dinstr_i.valid is high and rn_full_o is low; rinstr_o.valid mirrors that.
// rn_full_o depends only on registered state, so it never depends on
// same-cycle inputs.
module rename_ckpt
  import rename_pkg::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int NUM_CKPT  = 4
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  dinstr_t    dinstr_i,
  input  p_reg_t     p_commit_i,
  input  p_reg_t     retire_i,
  input  br_result_t br_result_i,
  output rinstr_t    rinstr_o,
  output logic       rn_full_o
);

  localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int FL_PTR_W = $clog2(FL_DEPTH) + 1;
  localparam int CK_AW    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
  localparam int CK_CW    = $clog2(NUM_CKPT + 1);

  map_t                 map_q, map_ren, map_d;
  logic [NUM_PREGS-1:0] ready_q, ready_d;

  map_t                 ck_map_q  [NUM_CKPT];
  logic [FL_PTR_W-1:0]  ck_head_q [NUM_CKPT];
  logic [CK_AW-1:0]     ck_rd_q, ck_wr_q;
  logic [CK_CW-1:0]     ck_cnt_q;

  logic                 fl_empty, fl_alloc;
  logic [PREG_W-1:0]    fl_head_idx;
  logic [FL_PTR_W-1:0]  fl_head_snap;

  logic has_rd, accept, flush, ck_any, ck_full, ck_pop, ck_push;

  function automatic logic [CK_AW-1:0] ck_next(logic [CK_AW-1:0] p);
    return (p == CK_AW'(NUM_CKPT - 1)) ? '0 : p + CK_AW'(1);
  endfunction

  // Source lookup with same-cycle writeback bypass.
  function automatic p_src_t read_src(a_reg_t a, map_t m,
                                      logic [NUM_PREGS-1:0] rdy, p_reg_t cm);
    p_src_t s;
    s.valid = a.valid;
    s.idx   = m[a.idx];
    s.ready = rdy[s.idx] | (cm.valid & (cm.idx == s.idx));
    return s;
  endfunction

  assign ck_any    = (ck_cnt_q != '0);
  assign ck_full   = (ck_cnt_q == CK_CW'(NUM_CKPT));
  assign rn_full_o = fl_empty | ck_full;
  // Gating with rst_ni keeps the output quiet for the whole reset pulse.
  assign accept    = rst_ni & dinstr_i.valid & ~rn_full_o;
  assign flush     = br_result_i.valid & ~br_result_i.hit & ck_any;
  assign ck_pop    = br_result_i.valid &  br_result_i.hit & ck_any;
  assign has_rd    = dinstr_i.rd.valid & (dinstr_i.rd.idx != '0);
  // A mispredict squashes the state effects of the same-cycle instruction.
  assign fl_alloc  = accept & has_rd & ~flush;
  assign ck_push   = accept & dinstr_i.is_branch & ~flush;

  rename_free_list #(
    .NUM_PREGS (NUM_PREGS)
  ) u_free_list (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .alloc_i        (fl_alloc),
    .retire_i       (retire_i),
    .restore_i      (flush),
    .restore_head_i (ck_head_q[ck_rd_q]),
    .head_idx_o     (fl_head_idx),
    .empty_o        (fl_empty),
    .head_snap_o    (fl_head_snap)
  );

  always_comb begin
    rinstr_o              = '0;
    rinstr_o.valid        = accept;
    rinstr_o.rd.valid     = has_rd;
    rinstr_o.rd.idx       = fl_head_idx;
    rinstr_o.old_rd.valid = has_rd;
    rinstr_o.old_rd.idx   = map_q[dinstr_i.rd.idx];
    rinstr_o.rs1          = read_src(dinstr_i.rs1, map_q, ready_q, p_commit_i);
    rinstr_o.rs2          = read_src(dinstr_i.rs2, map_q, ready_q, p_commit_i);
  end

  // map_ren includes this instruction's own rename; a branch checkpoints it.
  always_comb begin
    map_ren = map_q;
    if (fl_alloc) map_ren[dinstr_i.rd.idx] = fl_head_idx;
    map_d = flush ? ck_map_q[ck_rd_q] : map_ren;

    ready_d = ready_q;
    if (fl_alloc)         ready_d[fl_head_idx]   = 1'b0;
    // Writeback applies last so it is never lost to other activity.
    if (p_commit_i.valid) ready_d[p_commit_i.idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        map_q[i] <= PREG_W'(i);
      end
      ready_q  <= '1;
      ck_rd_q  <= '0;
      ck_wr_q  <= '0;
      ck_cnt_q <= '0;
    end else begin
      map_q   <= map_d;
      ready_q <= ready_d;
      if (flush) begin
        ck_rd_q  <= '0;
        ck_wr_q  <= '0;
        ck_cnt_q <= '0;
      end else begin
        if (ck_pop)  ck_rd_q <= ck_next(ck_rd_q);
        if (ck_push) ck_wr_q <= ck_next(ck_wr_q);
        ck_cnt_q <= ck_cnt_q + CK_CW'(ck_push) - CK_CW'(ck_pop);
      end
    end
  end

  // Checkpoint payload needs no reset: it is only read while ck_cnt_q > 0.
  always_ff @(posedge clk) begin
    if (ck_push) begin
      ck_map_q[ck_wr_q]  <= map_ren;
      ck_head_q[ck_wr_q] <= fl_head_snap;
    end
  end

endmodule

// File: tb/tb_rename_ckpt.sv
module tb_rename_ckpt;
  import rename_pkg::*;

  localparam int NUM_PREGS = 64;
  localparam int NUM_CKPT  = 4;

  logic clk;
  logic rst_ni;
  int   n_vec;
  int   n_err;

  rename_ckpt_if bus ();

  rename_ckpt #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_CKPT  (NUM_CKPT)
  ) dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .dinstr_i    (bus.dinstr),
    .p_commit_i  (bus.p_commit),
    .retire_i    (bus.retire),
    .br_result_i (bus.br_result),
    .rinstr_o    (bus.rinstr),
    .rn_full_o   (bus.rn_full)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_map [32];
  bit         m_ready [NUM_PREGS];
  int         free_q[$];
  int         hist[$];        // registers allocated, oldest first
  bit [255:0] ck_map_q[$];    // checkpointed maps, oldest first
  int         ck_mark_q[$];   // hist size when each checkpoint was taken
  int         spec_pos[$];    // speculative renames: position in hist
  int         spec_reg[$];    //   and the register they displaced
  int         dead_q[$];      // displaced registers safe to retire

  function automatic bit [255:0] pack_map();
    bit [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(m_map[i]);
    return v;
  endfunction

  function automatic bit model_full();
    return (free_q.size() == 0) || (ck_mark_q.size() == NUM_CKPT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = i;
    for (int i = 0; i < NUM_PREGS; i++) m_ready[i] = 1'b1;
    free_q.delete();
    for (int i = 32; i < NUM_PREGS; i++) free_q.push_back(i);
    hist.delete();
    ck_map_q.delete();
    ck_mark_q.delete();
    spec_pos.delete();
    spec_reg.delete();
    dead_q.delete();
  endtask

  task automatic model_update();
    bit         acc, hrd, flush, hit_pop, push;
    int         a, p, n, mark;
    bit [255:0] newmap, old;
    int         tp[$];
    int         tr[$];
    acc     = bus.dinstr.valid && !model_full();
    hrd     = bus.dinstr.rd.valid && (bus.dinstr.rd.idx != 0);
    flush   = bus.br_result.valid && !bus.br_result.hit && (ck_mark_q.size() > 0);
    hit_pop = bus.br_result.valid && bus.br_result.hit && (ck_mark_q.size() > 0);
    push    = acc && bus.dinstr.is_branch && !flush;
    if (acc && hrd && !flush) begin
      a = int'(bus.dinstr.rd.idx);
      p = free_q.pop_front();
      spec_pos.push_back(hist.size());
      spec_reg.push_back(m_map[a]);
      hist.push_back(p);
      m_ready[p] = 1'b0;
      m_map[a]   = p;
    end
    newmap = pack_map();
    mark   = hist.size();
    if (hit_pop) begin
      void'(ck_map_q.pop_front());
      void'(ck_mark_q.pop_front());
    end
    if (flush) begin
      old = ck_map_q[0];
      for (int i = 0; i < 32; i++) m_map[i] = int'(old[i*8 +: 8]);
      n = hist.size() - ck_mark_q[0];
      for (int i = 0; i < n; i++) free_q.push_front(hist.pop_back());
      for (int i = 0; i < spec_pos.size(); i++) begin
        if (spec_pos[i] < ck_mark_q[0]) begin
          tp.push_back(spec_pos[i]);
          tr.push_back(spec_reg[i]);
        end
      end
      spec_pos = tp;
      spec_reg = tr;
      ck_map_q.delete();
      ck_mark_q.delete();
    end
    if (bus.retire.valid) free_q.push_back(int'(bus.retire.idx));
    if (bus.p_commit.valid) m_ready[bus.p_commit.idx] = 1'b1;
    if (push) begin
      ck_map_q.push_back(newmap);
      ck_mark_q.push_back(mark);
    end
    // Renames older than every outstanding checkpoint can no longer be undone.
    tp.delete();
    tr.delete();
    for (int i = 0; i < spec_pos.size(); i++) begin
      if (ck_mark_q.size() == 0 || spec_pos[i] < ck_mark_q[0]) dead_q.push_back(spec_reg[i]);
      else begin
        tp.push_back(spec_pos[i]);
        tr.push_back(spec_reg[i]);
      end
    end
    spec_pos = tp;
    spec_reg = tr;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_src(string tag, p_src_t s, a_reg_t a);
    int  m;
    bit  rdy;
    m   = m_map[a.idx];
    rdy = m_ready[m] || (bus.p_commit.valid && int'(bus.p_commit.idx) == m);
    chk({tag, ".valid"}, 32'(s.valid), 32'(a.valid));
    chk({tag, ".idx"},   32'(s.idx),   32'(m));
    chk({tag, ".ready"}, 32'(s.ready), 32'(rdy));
  endtask

  task automatic check_outputs(string tag);
    bit exp_full, exp_valid, hrd;
    exp_full  = model_full();
    exp_valid = bus.dinstr.valid && !exp_full;
    hrd       = bus.dinstr.rd.valid && (bus.dinstr.rd.idx != 0);
    chk({tag, ".full"},  32'(bus.rn_full),      32'(exp_full));
    chk({tag, ".valid"}, 32'(bus.rinstr.valid), 32'(exp_valid));
    if (exp_valid) begin
      chk({tag, ".rd_v"}, 32'(bus.rinstr.rd.valid), 32'(hrd));
      if (hrd) begin
        chk({tag, ".rd"},     32'(bus.rinstr.rd.idx),     32'(free_q[0]));
        chk({tag, ".old_rd"}, 32'(bus.rinstr.old_rd.idx), 32'(m_map[bus.dinstr.rd.idx]));
      end
      chk_src({tag, ".rs1"}, bus.rinstr.rs1, bus.dinstr.rs1);
      chk_src({tag, ".rs2"}, bus.rinstr.rs2, bus.dinstr.rs2);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.dinstr    = '0;
    bus.p_commit  = '0;
    bus.retire    = '0;
    bus.br_result = '0;
  endtask

  task automatic set_dinstr(bit v, int rd, int rs1, int rs2, bit br);
    bus.dinstr.valid     = v;
    bus.dinstr.rd.valid  = 1'b1;
    bus.dinstr.rd.idx    = 5'(rd);
    bus.dinstr.rs1.valid = 1'b1;
    bus.dinstr.rs1.idx   = 5'(rs1);
    bus.dinstr.rs2.valid = 1'b1;
    bus.dinstr.rs2.idx   = 5'(rs2);
    bus.dinstr.is_branch = br;
  endtask

  // Inputs are set at posedge+1; outputs are sampled on the falling edge.
  task automatic sample(string tag);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic reset_dut();
    set_dinstr(1'b1, 1, 2, 3, 1'b0);
    rst_ni = 1'b0;
    #2;
    chk("rst.full",  32'(bus.rn_full),      32'd0);
    chk("rst.valid", 32'(bus.rinstr.valid), 32'd0);
    model_reset();
    @(negedge clk);
    chk("rst.full2",  32'(bus.rn_full),      32'd0);
    chk("rst.valid2", 32'(bus.rinstr.valid), 32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_ni = 1'b1;
    idle();
    #1;

    // Basic rename after reset, then dependency on the new mapping.
    reset_dut();
    set_dinstr(1'b1, 1, 2, 3, 1'b0);
    sample("r1");
    chk("r1.rd_lit",     32'(bus.rinstr.rd.idx),     32'd32);
    chk("r1.old_lit",    32'(bus.rinstr.old_rd.idx), 32'd1);
    chk("r1.rs1_lit",    32'(bus.rinstr.rs1.idx),    32'd2);
    chk("r1.rs1_rdy",    32'(bus.rinstr.rs1.ready),  32'd1);
    chk("r1.rs2_lit",    32'(bus.rinstr.rs2.idx),    32'd3);
    chk("r1.rs2_rdy",    32'(bus.rinstr.rs2.ready),  32'd1);
    advance();
    set_dinstr(1'b1, 0, 1, 0, 1'b0);
    sample("r2");
    chk("r2.rs1_lit", 32'(bus.rinstr.rs1.idx),   32'd32);
    chk("r2.rs1_rdy", 32'(bus.rinstr.rs1.ready), 32'd0);
    advance();
    // Writeback bypass in the same cycle as the read.
    set_dinstr(1'b1, 0, 1, 0, 1'b0);
    bus.p_commit = '{valid: 1'b1, idx: PREG_W'(32)};
    sample("byp");
    chk("byp.rs1_rdy", 32'(bus.rinstr.rs1.ready), 32'd1);
    advance();

    // Exhaust the free list, then recover with one retire.
    reset_dut();
    for (int i = 0; i < 32; i++) begin
      set_dinstr(1'b1, (i % 31) + 1, 0, 0, 1'b0);
      sample("fill");
      advance();
    end
    set_dinstr(1'b1, 3, 0, 0, 1'b0);
    sample("full");
    chk("full.flag",  32'(bus.rn_full),      32'd1);
    chk("full.valid", 32'(bus.rinstr.valid), 32'd0);
    advance();
    bus.retire = '{valid: 1'b1, idx: PREG_W'(5)};
    sample("ret");
    chk("ret.still_full", 32'(bus.rn_full), 32'd1);
    advance();
    set_dinstr(1'b1, 9, 0, 0, 1'b0);
    sample("reuse");
    chk("reuse.full", 32'(bus.rn_full),      32'd0);
    chk("reuse.rd",   32'(bus.rinstr.rd.idx), 32'd5);
    advance();

    // Mispredict restores map and free-list head.
    reset_dut();
    set_dinstr(1'b1, 4, 0, 0, 1'b1);
    sample("br");
    advance();
    set_dinstr(1'b1, 7, 0, 0, 1'b0);
    sample("spec");
    chk("spec.rd", 32'(bus.rinstr.rd.idx), 32'd33);
    advance();
    bus.br_result = '{valid: 1'b1, hit: 1'b0};
    sample("miss");
    advance();
    set_dinstr(1'b1, 8, 7, 4, 1'b0);
    sample("rest");
    chk("rest.rs1", 32'(bus.rinstr.rs1.idx), 32'd7);
    chk("rest.rs2", 32'(bus.rinstr.rs2.idx), 32'd32);
    chk("rest.rd",  32'(bus.rinstr.rd.idx),  32'd33);
    advance();

    // Checkpoint FIFO full, then a correct prediction frees a slot.
    reset_dut();
    for (int i = 0; i < NUM_CKPT; i++) begin
      set_dinstr(1'b1, i + 1, 0, 0, 1'b1);
      sample("ckfill");
      advance();
    end
    set_dinstr(1'b1, 0, 1, 0, 1'b0);
    sample("ckfull");
    chk("ckfull.flag",  32'(bus.rn_full),      32'd1);
    chk("ckfull.valid", 32'(bus.rinstr.valid), 32'd0);
    advance();
    bus.br_result = '{valid: 1'b1, hit: 1'b1};
    sample("hit");
    advance();
    set_dinstr(1'b1, 0, 1, 2, 1'b0);
    sample("posthit");
    chk("posthit.full", 32'(bus.rn_full),       32'd0);
    chk("posthit.rs1",  32'(bus.rinstr.rs1.idx), 32'd32);
    chk("posthit.rs2",  32'(bus.rinstr.rs2.idx), 32'd33);
    advance();

    // Reset pulse with two checkpoints outstanding.
    bus.br_result = '{valid: 1'b1, hit: 1'b1};
    sample("hit2");
    advance();
    chk("pre_rst.ckpts", 32'(ck_mark_q.size()), 32'd2);
    reset_dut();
    set_dinstr(1'b1, 10, 10, 4, 1'b0);
    sample("post_rst");
    chk("post_rst.full", 32'(bus.rn_full),       32'd0);
    chk("post_rst.rd",   32'(bus.rinstr.rd.idx), 32'd32);
    chk("post_rst.rs1",  32'(bus.rinstr.rs1.idx), 32'd10);
    chk("post_rst.rs2",  32'(bus.rinstr.rs2.idx), 32'd4);
    advance();

    // Randomized traffic against the model.
    reset_dut();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      set_dinstr($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 4) == 0);
      bus.dinstr.rd.valid  = ($urandom_range(0, 9) != 0);
      bus.dinstr.rs2.valid = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 1) != 0)
        bus.p_commit = '{valid: 1'b1, idx: PREG_W'($urandom_range(0, NUM_PREGS - 1))};
      if (dead_q.size() > 0 && $urandom_range(0, 2) == 0)
        bus.retire = '{valid: 1'b1, idx: PREG_W'(dead_q.pop_front())};
      if (ck_mark_q.size() > 0 && $urandom_range(0, 3) == 0)
        bus.br_result = '{valid: 1'b1, hit: ($urandom_range(0, 3) != 0)};
      sample("rnd");
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rename_ckpt.md
RENAME_CKPT -- requirements
Module: rename_ckpt

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, number of physical registers (power of two, >32).
REQ-002 SHALL have parameter NUM_CKPT, default 4, maximum number of unresolved branches (≥1).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port dinstr_i  in  dinstr_t  decoded instruction: valid, rd/rs1/rs2 {valid, 5-bit idx}, is_branch.
REQ-006 SHALL have port p_commit_i  in  p_reg_t  writeback notice {valid, idx}; marks physical idx ready.
REQ-007 SHALL have port retire_i  in  p_reg_t  {valid, idx}; returns physical idx to the free list.
REQ-008 SHALL have port br_result_i  in  br_result_t  {valid, hit}; resolves the oldest outstanding branch.
REQ-009 SHALL have port rinstr_o  out  rinstr_t  renamed instruction: valid, rd/old_rd {valid, idx}, rs1/rs2 {valid, idx, ready}.
REQ-010 SHALL have port rn_full_o  out  1  cannot accept an instruction this cycle.

Function
REQ-011 SHALL produce rinstr_o combinationally from dinstr_i in the same cycle (zero latency); the map, free list, ready and checkpoint state SHALL update at the next rising edge.
REQ-012 SHALL assert rn_full_o when the registered free count is 0 or the checkpoint count equals NUM_CKPT; a retire in the same cycle SHALL NOT clear it.
REQ-013 SHALL drive rinstr_o.valid = dinstr_i.valid & ~rn_full_o; an instruction presented while full SHALL have no state effect.
REQ-014 SHALL give rs1/rs2 idx = map[arch idx], ready = ready[idx] | (p_commit_i.valid & p_commit_i.idx==idx); arch 0 SHALL map to p0, which is always ready.
REQ-015 SHALL treat rd.idx==0 as no destination (rinstr_o.rd.valid=0, no allocation).
REQ-016 SHALL, for a valid rd, output the free-list head as rd.idx and the previous mapping as old_rd, then update map[rd], clear ready[new idx], and advance the head.
REQ-017 SHALL implement the free list as a circular FIFO of NUM_PREGS-32 entries with wrap-bit pointers; retire_i pushes at the tail and may coincide with an allocation.
REQ-018 SHALL, on an accepted is_branch instruction, push a checkpoint (full map table plus free-list head pointer) to a FIFO of NUM_CKPT entries, after applying that instruction's own rename.
REQ-019 SHALL, on br_result_i.valid & hit, pop the oldest checkpoint; a push in the same cycle is allowed.
REQ-020 SHALL, on br_result_i.valid & ~hit, restore the map and free-list head from the oldest checkpoint, discard all checkpoints, and suppress the state effects of any instruction accepted that cycle (rinstr_o is still driven).
REQ-021 SHALL ignore br_result_i while no checkpoint is outstanding.
REQ-022 SHALL apply p_commit_i to the ready table regardless of rename or branch activity in the same cycle.

Reset
REQ-023 SHALL, while rst_ni=0, set map[i]=i for i<32, ready all 1, free list holding 32..NUM_PREGS-1 in ascending order, and checkpoint count 0.
REQ-024 SHALL hold rn_full_o=0 and rinstr_o.valid=0 throughout reset; an assertion mid-operation SHALL discard all speculative state immediately.

Structure
REQ-025 SHALL take NUM_AREGS=32, PREG_W=$clog2(NUM_PREGS) and the dinstr_t, rinstr_t, p_reg_t and br_result_t types from the shared rename_pkg.
REQ-026 SHALL place the free-list FIFO, including head snapshot and restore, in sub-module rename_free_list; checkpoint storage SHALL stay in rename_ckpt.

Verification
REQ-027 SHALL verify: after reset, rd=1, rs1=2, rs2=3 -> rd=32, old_rd=1, rs1={2,ready}, rs2={3,ready}; then rs1=1 -> {32,not ready}.
REQ-028 SHALL verify: p_commit idx=32 in the same cycle as a read of arch 1 -> rs1.ready=1 (bypass).
REQ-029 SHALL verify: allocate 32 destinations without retire -> rn_full_o=1 and the next valid dinstr gives rinstr_o.valid=0; one retire of idx 5 -> rn_full_o=0 the following cycle and the next rd gets 5.
REQ-030 SHALL verify: branch, then rd=7 (gets 33), then br_result{1,0} -> arch 7 maps to 7 again and the next rd gets 33.
REQ-031 SHALL verify: NUM_CKPT branches outstanding -> rn_full_o=1; br_result{1,1} -> rn_full_o=0 next cycle and the mappings are unchanged.
REQ-032 SHALL verify: rst_ni pulsed low mid-stream with 2 checkpoints outstanding -> identity map, rd gets 32, rn_full_o=0.
